product_accumulator: RTL and testbench

//  Sequential stage directly downstream of the 4x4 array multiplier.

---
 rtl/product_accumulator.sv | 105 ++++++++++
 tb/tb_product_accumulator.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Accumulates N_TERMS unsigned 8-bit products into one ACC_W-bit sum and
// presents it over a valid/ready port. Define ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module product_accumulator #(
    parameter int ACC_W   = 12,
    parameter int N_TERMS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [7:0]       product,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic [7:0]       term_cnt
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic             w_accept;
    logic [ACC_W:0]   w_sum;

`ifdef ACC_SATURATE_EN
    function automatic logic [ACC_W-1:0] sat_clamp(input logic [ACC_W:0] sum);
        sat_clamp = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    endfunction
`endif

    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_DONE);
    assign acc_out   = r_acc;
    assign overflow  = r_ovf;
    assign term_cnt  = r_cnt;
    assign w_accept  = in_valid & in_ready;

    // One extra bit so the carry out of the accumulator is visible.
    assign w_sum = {1'b0, r_acc} + {{(ACC_W-7){1'b0}}, product};

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        if (clear) begin
            w_state_nxt = ST_ACCUM;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
`ifdef ACC_SATURATE_EN
                        w_acc_nxt = sat_clamp(w_sum);
`else
                        w_acc_nxt = w_sum[ACC_W-1:0];
`endif
                        w_cnt_nxt = r_cnt + 8'd1;
                        w_ovf_nxt = r_ovf | w_sum[ACC_W];
                        if (r_cnt == 8'(N_TERMS - 1)) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Result and overflow hold until the consumer takes them.
                    if (out_ready) begin
                        w_state_nxt = ST_ACCUM;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_ovf_nxt   = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three instances (12/4, 8/2, 12/1) checked against a
// group-sum model every cycle, plus literal expectations. Honours ACC_SATURATE_EN.
module tb_product_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       clr  [3];
    logic       vld  [3];
    logic       ordy [3];
    logic [7:0] prod [3];
    logic       ir   [3];
    logic       ov   [3];
    logic       ovf  [3];
    logic [7:0] tc   [3];
    logic [11:0] acc0;
    logic [7:0]  acc1;
    logic [11:0] acc2;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

`ifdef ACC_SATURATE_EN
    localparam int EXP_T3 = 255;
`else
    localparam int EXP_T3 = 194;
`endif

    product_accumulator #(.ACC_W(12), .N_TERMS(4)) u0 (
        .clk(clk), .rst_n(rst_n), .clear(clr[0]), .product(prod[0]), .in_valid(vld[0]),
        .in_ready(ir[0]), .acc_out(acc0), .out_valid(ov[0]), .out_ready(ordy[0]),
        .overflow(ovf[0]), .term_cnt(tc[0]));
    product_accumulator #(.ACC_W(8), .N_TERMS(2)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clr[1]), .product(prod[1]), .in_valid(vld[1]),
        .in_ready(ir[1]), .acc_out(acc1), .out_valid(ov[1]), .out_ready(ordy[1]),
        .overflow(ovf[1]), .term_cnt(tc[1]));
    product_accumulator #(.ACC_W(12), .N_TERMS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .clear(clr[2]), .product(prod[2]), .in_valid(vld[2]),
        .in_ready(ir[2]), .acc_out(acc2), .out_valid(ov[2]), .out_ready(ordy[2]),
        .overflow(ovf[2]), .term_cnt(tc[2]));

    // Model: true integer sum of the products in the current group.
    typedef struct {
        int     n;
        int     w;
        int     cnt;
        longint sum;
        bit     done;
    } mdl_t;

    mdl_t m [3];

    function automatic mdl_t mclear(mdl_t s);
        mdl_t t;
        t      = s;
        t.cnt  = 0;
        t.sum  = 0;
        t.done = 1'b0;
        return t;
    endfunction

    function automatic mdl_t mstep(mdl_t s, logic c, logic v, logic [7:0] p, logic r);
        mdl_t t;
        t = s;
        if (c) begin
            t = mclear(s);
        end else if (!s.done) begin
            if (v) begin
                t.sum = t.sum + longint'(p);
                t.cnt = t.cnt + 1;
                if (t.cnt == t.n) t.done = 1'b1;
            end
        end else if (r) begin
            t = mclear(s);
        end
        return t;
    endfunction

    function automatic longint mmax(mdl_t s);
        return (longint'(1) << s.w) - 1;
    endfunction

    function automatic longint macc(mdl_t s);
`ifdef ACC_SATURATE_EN
        return (s.sum > mmax(s)) ? mmax(s) : s.sum;
`else
        return s.sum % (mmax(s) + 1);
`endif
    endfunction

    initial begin
        m[0] = '{n: 4, w: 12, cnt: 0, sum: 0, done: 1'b0};
        m[1] = '{n: 2, w: 8,  cnt: 0, sum: 0, done: 1'b0};
        m[2] = '{n: 1, w: 12, cnt: 0, sum: 0, done: 1'b0};
    end

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) m[i] = mclear(m[i]);
            else        m[i] = mstep(m[i], clr[i], vld[i], prod[i], ordy[i]);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input int i, input logic [63:0] acc, input logic rdy, input logic vl,
                       input logic of, input logic [7:0] cnt);
        chk($sformatf("d%0d_acc_out", i), acc, 64'(macc(m[i])));
        chk($sformatf("d%0d_in_ready", i), 64'(rdy), 64'(!m[i].done));
        chk($sformatf("d%0d_out_valid", i), 64'(vl), 64'(m[i].done));
        chk($sformatf("d%0d_overflow", i), 64'(of), 64'(m[i].sum > mmax(m[i])));
        chk($sformatf("d%0d_term_cnt", i), 64'(cnt), 64'(m[i].cnt));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, 64'(acc0), ir[0], ov[0], ovf[0], tc[0]);
            cmp(1, 64'(acc1), ir[1], ov[1], ovf[1], tc[1]);
            cmp(2, 64'(acc2), ir[2], ov[2], ovf[2], tc[2]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         nres;
        logic [7:0] last;
        nres = 0;
        last = '0;
        for (int i = 0; i < 3; i++) begin
            clr[i] = 1'b0; vld[i] = 1'b0; ordy[i] = 1'b0; prod[i] = '0;
        end
        rst_n = 1'b0;
        repeat (2) step();
        chk("rst_acc0", 64'(acc0), 0);
        chk("rst_tc0", 64'(tc[0]), 0);
        chk("rst_ir0", 64'(ir[0]), 1);
        chk("rst_ov1", 64'(ov[1]), 0);
        chk("rst_ovf1", 64'(ovf[1]), 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        step();

        // Back-to-back group, consumer always ready
        ordy[0] = 1'b1; vld[0] = 1'b1;
        prod[0] = 8'd15; step();
        prod[0] = 8'd30; step();
        prod[0] = 8'd45; step();
        chk("t1_not_done_yet", 64'(ov[0]), 0);
        prod[0] = 8'd60; step();
        vld[0] = 1'b0;
        chk("t1_out_valid", 64'(ov[0]), 1);
        chk("t1_acc_out", 64'(acc0), 150);
        chk("t1_overflow", 64'(ovf[0]), 0);
        step();
        chk("t1_taken_ready", 64'(ir[0]), 1);
        chk("t1_taken_acc", 64'(acc0), 0);

        // Result held in DONE while upstream keeps offering 99
        ordy[0] = 1'b0; vld[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            prod[0] = 8'(10 * k); step();
        end
        prod[0] = 8'd99;
        for (int k = 0; k < 5; k++) begin
            chk("t2_in_ready_low", 64'(ir[0]), 0);
            chk("t2_acc_stable", 64'(acc0), 100);
            step();
        end
        ordy[0] = 1'b1; prod[0] = 8'd7; step();
        chk("t2_release_acc", 64'(acc0), 0);
        ordy[0] = 1'b0; step();
        chk("t2_new_group_acc", 64'(acc0), 7);
        chk("t2_new_group_cnt", 64'(tc[0]), 1);
        vld[0] = 1'b0; clr[0] = 1'b1; step(); clr[0] = 1'b0;
        chk("t2_cleared_cnt", 64'(tc[0]), 0);

        // Clear mid-group, then a fresh group
        vld[0] = 1'b1;
        prod[0] = 8'd20; step();
        prod[0] = 8'd30; step();
        chk("t4_partial", 64'(acc0), 50);
        clr[0] = 1'b1; prod[0] = 8'd5; step(); clr[0] = 1'b0;
        chk("t4_clear_acc", 64'(acc0), 0);
        chk("t4_clear_cnt", 64'(tc[0]), 0);
        for (int k = 1; k <= 4; k++) begin
            prod[0] = 8'(k); step();
        end
        vld[0] = 1'b0;
        chk("t4_acc_out", 64'(acc0), 10);
        chk("t4_out_valid", 64'(ov[0]), 1);
        chk("t4_overflow", 64'(ovf[0]), 0);
        ordy[0] = 1'b1; step(); ordy[0] = 1'b0;

        // 8-bit accumulator overflow, then clear while DONE
        vld[1] = 1'b1; prod[1] = 8'd225; step(); step(); vld[1] = 1'b0;
        chk("t3_acc_out", 64'(acc1), 64'(EXP_T3));
        chk("t3_overflow", 64'(ovf[1]), 1);
        chk("t3_out_valid", 64'(ov[1]), 1);
        ordy[1] = 1'b1; step(); ordy[1] = 1'b0;
        chk("t3_taken_ovf", 64'(ovf[1]), 0);
        vld[1] = 1'b1; prod[1] = 8'd1; step(); prod[1] = 8'd2; step(); vld[1] = 1'b0;
        chk("t3_second_acc", 64'(acc1), 3);
        clr[1] = 1'b1; step(); clr[1] = 1'b0;
        chk("t3_clear_done_ov", 64'(ov[1]), 0);
        chk("t3_clear_done_acc", 64'(acc1), 0);

        // Asynchronous reset mid-group (d0) and mid-DONE (d1)
        vld[0] = 1'b1; prod[0] = 8'd9; vld[1] = 1'b1; prod[1] = 8'd4;
        step(); step();
        vld[0] = 1'b0; vld[1] = 1'b0;
        chk("t5_pre_cnt0", 64'(tc[0]), 2);
        chk("t5_pre_ov1", 64'(ov[1]), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_cnt0", 64'(tc[0]), 0);
        chk("t5_rst_acc0", 64'(acc0), 0);
        chk("t5_rst_ir0", 64'(ir[0]), 1);
        chk("t5_rst_ov1", 64'(ov[1]), 0);
        chk("t5_rst_acc1", 64'(acc1), 0);
        chk("t5_rst_ir1", 64'(ir[1]), 1);
        #1 rst_n = 1'b1;
        vld[0] = 1'b1;
        for (int k = 5; k <= 8; k++) begin
            prod[0] = 8'(k); step();
        end
        vld[0] = 1'b0;
        chk("t5_after_acc", 64'(acc0), 26);
        chk("t5_after_ov", 64'(ov[0]), 1);
        ordy[0] = 1'b1; step(); ordy[0] = 1'b0;

        // Single-term groups, continuous valid
        ordy[2] = 1'b1; vld[2] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            prod[2] = 8'(11 + k * 13);
            if (ir[2]) last = prod[2];
            step();
            if (ov[2]) begin
                nres++;
                chk("t6_acc_eq_product", 64'(acc2), 64'(last));
            end
        end
        vld[2] = 1'b0;
        chk("t6_results_in_8", 64'(nres), 4);

        repeat (3) step();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
